reg_pipeline_delay: RTL and testbench



---
 rtl/reg_pipeline_delay.sv | 78 +++++++
 tb/tb_reg_pipeline_delay.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_pipeline_delay.sv
// WIDTH-bit, DEPTH-stage register delay line with per-stage valid bits,
// clock-enable stall, synchronous flush, runtime-selectable tap and a
// saturating fill counter. Outputs are muxed from registered state only.
module reg_pipeline_delay #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [SW-1:0]    delay_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [SW-1:0]    fill_count,
    output logic             primed
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] v;
    logic [SW-1:0]    eff_delay;
    logic [SW-1:0]    tap;

    // Clamp the requested delay into 1..DEPTH; zero means the shortest delay.
    always_comb begin
        eff_delay = delay_sel;
        if (delay_sel == '0) begin
            eff_delay = SW'(1);
        end else if (delay_sel > SW'(DEPTH)) begin
            eff_delay = SW'(DEPTH);
        end
        tap = eff_delay - SW'(1);
    end

    // Shift data and valid bits one stage per enabled edge; reset/flush clear everything.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= RESET_VALUE;
            end
            v <= '0;
        end else if (en) begin
            stage[0] <= in_data;
            v[0]     <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
                v[k]     <= v[k-1];
            end
        end
    end

    // Count enabled edges since the last clear, holding once the line is full.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            fill_count <= '0;
        end else if (en && (fill_count < SW'(DEPTH))) begin
            fill_count <= fill_count + SW'(1);
        end
    end

    // Select the output tap; compare against each index to keep the mux width-exact.
    always_comb begin
        out_data  = stage[0];
        out_valid = v[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == SW'(k)) begin
                out_data  = stage[k];
                out_valid = v[k];
            end
        end
        primed = (fill_count >= eff_delay);
    end

endmodule

// File: tb/tb_reg_pipeline_delay.sv
// Bench for reg_pipeline_delay: directed sequences plus randomized traffic,
// checked against a history-queue model through a scoreboard and monitor.
module tb_reg_pipeline_delay;

    localparam int               W  = 16;
    localparam int               D  = 8;
    localparam int               SW = $clog2(D + 1);
    localparam logic [W-1:0]     RV = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] delay_sel = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [SW-1:0] fill_count;
    logic          primed;

    reg_pipeline_delay #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .delay_sel  (delay_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .fill_count (fill_count),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        int           f;
        logic         p;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         v;
    } smp_t;

    exp_t sbq[$];
    smp_t hist[$];
    int   n_en = 0;
    bit   known = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic int eff_of(input int ds);
        if (ds == 0) return 1;
        if (ds > D) return D;
        return ds;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: output is the sample accepted eff edges ago, if that many edges happened.
    task automatic expect_now(input int ds);
        exp_t e;
        int   eff;
        if (!known) return;
        eff = eff_of(ds);
        if (n_en >= eff) begin
            e.d = hist[hist.size() - eff].d;
            e.v = hist[hist.size() - eff].v;
        end else begin
            e.d = RV;
            e.v = 1'b0;
        end
        e.f = (n_en > D) ? D : n_en;
        e.p = (e.f >= eff);
        sbq.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit f, input bit e, input logic [W-1:0] d,
                         input bit iv, input int ds);
        reset     = r;
        flush     = f;
        en        = e;
        in_data   = d;
        in_valid  = iv;
        delay_sel = ds[SW-1:0];
        expect_now(ds);
        @(posedge clk);
        if (r || f) begin
            known = 1;
            n_en  = 0;
            hist.delete();
        end else if (e && known) begin
            hist.push_back('{d, iv});
            if (hist.size() > D) void'(hist.pop_front());
            n_en++;
        end
        #1;
    endtask

    // Monitor: outputs are always presented, so compare one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_data",   32'(out_data),   32'(e.d));
                chk("out_valid",  32'(out_valid),  32'(e.v));
                chk("fill_count", 32'(fill_count), 32'(e.f));
                chk("primed",     32'(primed),     32'(e.p));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset, then stream 1,2,3,... at delay 3
        cycle(1, 0, 0, 16'h0, 0, 3);
        cycle(1, 0, 0, 16'h0, 0, 3);
        chk("reset_primed", 32'(primed), 32'(0));
        chk("reset_fill", 32'(fill_count), 32'(0));
        chk("reset_valid", 32'(out_valid), 32'(0));
        for (int i = 1; i <= 3; i++) cycle(0, 0, 1, 16'(i), 1, 3);
        chk("first_out", 32'(out_data), 32'(1));
        chk("first_valid", 32'(out_valid), 32'(1));
        chk("first_primed", 32'(primed), 32'(1));
        chk("first_fill", 32'(fill_count), 32'(3));
        for (int i = 4; i <= 6; i++) cycle(0, 0, 1, 16'(i), 1, 3);
        chk("pre_stall_out", 32'(out_data), 32'(4));
        // Stall two cycles
        cycle(0, 0, 0, 16'h7, 1, 3);
        cycle(0, 0, 0, 16'h7, 1, 3);
        chk("stall_out", 32'(out_data), 32'(4));
        chk("stall_fill", 32'(fill_count), 32'(6));
        for (int i = 7; i <= 12; i++) cycle(0, 0, 1, 16'(i), 1, 3);
        chk("sat_fill", 32'(fill_count), 32'(8));
        chk("after_stall_out", 32'(out_data), 32'(10));
        // Flush with a sample offered that must never emerge
        cycle(0, 1, 1, 16'h99, 1, 3);
        chk("flush_valid", 32'(out_valid), 32'(0));
        chk("flush_data", 32'(out_data), 32'(0));
        chk("flush_primed", 32'(primed), 32'(0));
        for (int i = 20; i <= 23; i++) cycle(0, 0, 1, 16'(i), 1, 3);
        // Minimum and clamped-maximum delay
        for (int i = 30; i <= 35; i++) cycle(0, 0, 1, 16'(i), 1, 0);
        chk("delay0_out", 32'(out_data), 32'(35));
        cycle(0, 1, 0, 16'h0, 0, 15);
        for (int i = 40; i <= 50; i++) cycle(0, 0, 1, 16'(i), 1, 15);
        chk("delay15_out", 32'(out_data), 32'(43));
        // Full line of 10..17 at delay 2, then move the tap to 5
        cycle(1, 0, 0, 16'h0, 0, 2);
        for (int i = 10; i <= 17; i++) cycle(0, 0, 1, 16'(i), 1, 2);
        chk("tap2_out", 32'(out_data), 32'(16));
        cycle(0, 0, 0, 16'h0, 0, 5);
        chk("tap5_out", 32'(out_data), 32'(13));
        chk("tap5_primed", 32'(primed), 32'(1));
        cycle(0, 1, 0, 16'h0, 0, 5);
        for (int i = 60; i <= 66; i++) cycle(0, 0, 1, 16'(i), (i != 62), 5);
        // Reset mid-stream with a valid sample offered
        cycle(1, 0, 1, 16'h55, 1, 3);
        chk("midreset_valid", 32'(out_valid), 32'(0));
        chk("midreset_fill", 32'(fill_count), 32'(0));
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(39) == 0),
                  ($urandom_range(3) != 0), W'($urandom),
                  ($urandom_range(3) != 0), int'($urandom_range(15)));
        end
        reset = 0; flush = 0; en = 0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
